// File: rtl/rx_sipo_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default frame geometry and the bit positions of each frame field.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2
    } rx_state_e;

    localparam int FRAME_BITS = 11;
    localparam int OVERSAMPLE = 16;

    // Field positions inside DataParl; the start bit is received first
    localparam int START_IDX = 10;
    localparam int DATA_HI   = 9;
    localparam int DATA_LO   = 2;
    localparam int PAR_IDX   = 1;
    localparam int STOP_IDX  = 0;

endpackage

// File: rtl/rx_sipo_if.sv
// Frame hand-off from the serial front end to the deframing stage.
interface rx_sipo_if #(
    parameter int FRAME_BITS = uart_rx_pkg::FRAME_BITS
);

    logic [FRAME_BITS-1:0] DataParl;
    logic                  RecievedFlag;
    logic                  RxBusy;

    modport master (
        output DataParl,
        output RecievedFlag,
        output RxBusy
    );

    modport slave (
        input DataParl,
        input RecievedFlag,
        input RxBusy
    );

endinterface

// File: rtl/rx_sipo_sync.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset
// to RESET_VAL so the line looks idle straight out of reset.
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rx_sipo.sv
// UART receive front end: start-bit validation with oversampling, mid-bit
// sampling of the whole frame and a level flag for the completed frame.
module rx_sipo
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = uart_rx_pkg::OVERSAMPLE,
    parameter int FRAME_BITS = uart_rx_pkg::FRAME_BITS
) (
    input  logic           Clk,
    input  logic           ResetN,
    input  logic           BaudTick,
    input  logic           RxIn,
    rx_sipo_if.master      rx_o
);

    localparam int TCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(FRAME_BITS);

    localparam logic [TCNT_W-1:0] HALF_LAST = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(FRAME_BITS - 1);

    logic rxs;

    rx_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (Clk),
        .rst_n (ResetN),
        .d     (RxIn),
        .q     (rxs)
    );

    rx_state_e             state_d, state_q;
    logic [TCNT_W-1:0]     tcnt_d,  tcnt_q;
    logic [BCNT_W-1:0]     bcnt_d,  bcnt_q;
    logic [FRAME_BITS-1:0] sh_d,    sh_q;
    logic [FRAME_BITS-1:0] data_d,  data_q;
    logic                  flag_d,  flag_q;
    logic                  busy_d,  busy_q;

    // NOTE: every always_comb output gets a hold default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        flag_d  = flag_q;

        if (BaudTick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_d = ST_START;
                        tcnt_d  = '0;
                    end
                end

                ST_START: begin
                    if (tcnt_q == HALF_LAST) begin
                        if (!rxs) begin
                            sh_d    = {sh_q[FRAME_BITS-2:0], 1'b0};
                            bcnt_d  = BCNT_W'(1);
                            tcnt_d  = '0;
                            flag_d  = 1'b0;
                            state_d = ST_DATA;
                        end else begin
                            // Line went back high before mid-bit: a glitch, not a start
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (tcnt_q == TICK_LAST) begin
                        tcnt_d = '0;
                        sh_d   = {sh_q[FRAME_BITS-2:0], rxs};
                        if (bcnt_q == BIT_LAST) begin
                            // Leave mid-stop-bit so a back-to-back start edge is not missed
                            data_d  = {sh_q[FRAME_BITS-2:0], rxs};
                            flag_d  = 1'b1;
                            bcnt_d  = '0;
                            state_d = ST_IDLE;
                        end else begin
                            bcnt_d = bcnt_q + BCNT_W'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: the shift register is reset too, so a frame never carries stale bits from before reset.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '1;
            data_q  <= '1;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_o.DataParl     = data_q;
    assign rx_o.RecievedFlag = flag_q;
    assign rx_o.RxBusy       = busy_q;

endmodule

// File: tb/tb_rx_sipo.sv
// Directed bench for rx_sipo: frames are queued as expected values and a
// monitor compares DataParl on every rising edge of RecievedFlag.
module tb_rx_sipo;
    import uart_rx_pkg::*;

    logic Clk      = 1'b0;
    logic ResetN   = 1'b0;
    logic BaudTick = 1'b0;
    logic RxIn     = 1'b1;

    rx_sipo_if #(.FRAME_BITS(FRAME_BITS)) rx_if ();

    rx_sipo #(
        .OVERSAMPLE (OVERSAMPLE),
        .FRAME_BITS (FRAME_BITS)
    ) dut (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .BaudTick (BaudTick),
        .RxIn     (RxIn),
        .rx_o     (rx_if)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int tick_div = 1;
    logic [FRAME_BITS-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Tick generator: one BaudTick every tick_div cycles, changed on the falling edge
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(negedge Clk);
            phase++;
            if (phase >= tick_div) begin
                phase = 0;
                BaudTick = 1'b1;
            end else begin
                BaudTick = 1'b0;
            end
        end
    end

    // Monitor: each new frame is announced by a rising RecievedFlag
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (rx_if.RecievedFlag === 1'b1 && prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %0h expected none", rx_if.DataParl);
                end else begin
                    logic [FRAME_BITS-1:0] e;
                    e = exp_q.pop_front();
                    check("frame", 32'(rx_if.DataParl), 32'(e));
                end
            end
            prev = rx_if.RecievedFlag;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge Clk);
            if (BaudTick) k++;
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge Clk);
        RxIn = b;
        wait_ticks(OVERSAMPLE);
    endtask

    task automatic send_frame(input logic [FRAME_BITS-1:0] f);
        exp_q.push_back(f);
        for (int i = FRAME_BITS - 1; i >= 0; i--) send_bit(f[i]);
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        RxIn = 1'b1;
        wait_ticks(n);
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(negedge Clk);
            c++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [FRAME_BITS-1:0] part;

        // Reset state
        repeat (3) @(negedge Clk);
        check("reset_data", 32'(rx_if.DataParl), 32'h7FF);
        check("reset_flag", 32'(rx_if.RecievedFlag), 32'd0);
        check("reset_busy", 32'(rx_if.RxBusy), 32'd0);
        @(negedge Clk);
        ResetN = 1'b1;
        idle(20);

        // Basic frame, tick every cycle
        send_frame(11'h295);
        idle(20);
        drain("frame1_seen");
        check("frame1_flag", 32'(rx_if.RecievedFlag), 32'd1);
        check("frame1_busy", 32'(rx_if.RxBusy), 32'd0);

        // Glitch shorter than half a bit
        @(negedge Clk);
        RxIn = 1'b0;
        wait_ticks(4);
        @(negedge Clk);
        check("glitch_busy", 32'(rx_if.RxBusy), 32'd1);
        RxIn = 1'b1;
        wait_ticks(30);
        @(negedge Clk);
        check("glitch_data", 32'(rx_if.DataParl), 32'h295);
        check("glitch_flag", 32'(rx_if.RecievedFlag), 32'd1);
        check("glitch_busy_end", 32'(rx_if.RxBusy), 32'd0);

        // Back-to-back frames, no idle gap
        send_frame(11'h295);
        send_frame(11'h1FF);
        idle(20);
        drain("b2b_seen");

        // Stop bit of 0 delivered as-is
        send_frame(11'h294);
        idle(40);
        drain("stop0_seen");
        check("stop0_bit", 32'(rx_if.DataParl[STOP_IDX]), 32'd0);
        check("stop0_flag", 32'(rx_if.RecievedFlag), 32'd1);
        check("stop0_busy", 32'(rx_if.RxBusy), 32'd0);

        // Reset after data bit 4
        part = 11'h295;
        for (int i = FRAME_BITS - 1; i >= FRAME_BITS - 5; i--) send_bit(part[i]);
        wait_ticks(5);
        @(negedge Clk);
        ResetN = 1'b0;
        RxIn   = 1'b1;
        #1;
        check("midrst_data", 32'(rx_if.DataParl), 32'h7FF);
        check("midrst_flag", 32'(rx_if.RecievedFlag), 32'd0);
        check("midrst_busy", 32'(rx_if.RxBusy), 32'd0);
        @(negedge Clk);
        ResetN = 1'b1;
        idle(40);
        send_frame(11'h3C3);
        idle(20);
        drain("post_rst_seen");

        // Sparse ticks: one every 5 cycles
        tick_div = 5;
        idle(5);
        send_frame(11'h295);
        idle(20);
        drain("sparse_seen");
        check("sparse_data", 32'(rx_if.DataParl), 32'h295);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
